// File: rtl/audio_sample_sequencer.sv
// rtl/audio_sample_sequencer.sv - flash word sequencer that splits 32-bit words into 16-bit audio samples
//
// Purpose:
//   Requests 32-bit words from the flash reader, splits each word into two
//   16-bit samples and issues one sample per sample_tick. Supports pause,
//   reverse playback, restart and wrap-around within [START_ADDR, END_ADDR].
//
// Ports:
//   clk          in   system clock
//   reset        in   synchronous active-low reset
//   sample_tick  in   1-cycle strobe at the audio sample rate
//   play         in   1 = run, 0 = pause
//   reverse      in   1 = descending addresses, high half first
//   restart      in   1-cycle pulse: jump to START_ADDR (fwd) / END_ADDR (rev)
//   read_start   out  read request to the flash reader
//   read_addr    out  word address of the request
//   read_data    in   word returned by the flash reader
//   read_done    in   read_data valid this cycle
//   sample_out   out  current audio sample (registered)
//   sample_valid out  1-cycle pulse when sample_out updates
//   underrun     out  1-cycle pulse when a tick is lost

module audio_sample_sequencer #(
  parameter int                ADDR_W     = 24,
  parameter logic [ADDR_W-1:0] START_ADDR = 24'h000000,
  parameter logic [ADDR_W-1:0] END_ADDR   = 24'h07FFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_tick,
  input  logic              play,
  input  logic              reverse,
  input  logic              restart,
  output logic              read_start,
  output logic [ADDR_W-1:0] read_addr,
  input  logic [31:0]       read_data,
  input  logic              read_done,
  output logic [15:0]       sample_out,
  output logic              sample_valid,
  output logic              underrun
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FETCH  = 2'd1;
  localparam logic [1:0] S_FIRST  = 2'd2;
  localparam logic [1:0] S_SECOND = 2'd3;

  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

  logic [1:0]        state;
  logic [31:0]       word;
  logic              word_rev;      // direction captured when the word entered FIRST
  logic              pending;       // one tick remembered while the word is not ready
  logic              restart_pend;  // restart seen during an in-flight fetch
  logic [ADDR_W-1:0] next_addr;
  logic [ADDR_W-1:0] restart_addr;
  logic [15:0]       first_half;
  logic [15:0]       second_half;
  logic              consume;

  always_comb begin
    restart_addr = reverse ? END_ADDR : START_ADDR;
    next_addr    = read_addr;
    if (reverse) begin
      next_addr = (read_addr == START_ADDR) ? END_ADDR : read_addr - ADDR_ONE;
    end else begin
      next_addr = (read_addr == END_ADDR) ? START_ADDR : read_addr + ADDR_ONE;
    end
    first_half  = word_rev ? word[31:16] : word[15:0];
    second_half = word_rev ? word[15:0]  : word[31:16];
    consume     = play && !restart && (sample_tick || pending);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= S_IDLE;
      read_start   <= 1'b0;
      read_addr    <= START_ADDR;
      word         <= '0;
      word_rev     <= 1'b0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      underrun     <= 1'b0;
      pending      <= 1'b0;
      restart_pend <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      underrun     <= 1'b0;

      case (state)
        S_IDLE: begin
          if (restart) begin
            read_addr  <= restart_addr;
            pending    <= 1'b0;
            state      <= S_FETCH;
            read_start <= 1'b1;
          end else if (play) begin
            state      <= S_FETCH;
            read_start <= 1'b1;
          end
        end

        S_FETCH: begin
          // The flash handshake is never aborted; restart is deferred until done.
          if (!play) begin
            pending <= 1'b0;
          end else if (!restart && sample_tick) begin
            if (pending) underrun <= 1'b1;
            else         pending  <= 1'b1;
          end
          if (restart) restart_pend <= 1'b1;

          if (read_start && read_done) begin
            word       <= read_data;
            read_start <= 1'b0;
            if (restart_pend || restart) begin
              // Word discarded; the request is re-issued on the following cycle.
              read_addr    <= restart_addr;
              restart_pend <= 1'b0;
            end else begin
              word_rev <= reverse;
              state    <= S_FIRST;
            end
          end else if (!read_start) begin
            read_start <= 1'b1;
          end
        end

        S_FIRST, S_SECOND: begin
          if (restart) begin
            read_addr  <= restart_addr;
            pending    <= 1'b0;
            state      <= S_FETCH;
            read_start <= 1'b1;
          end else if (!play) begin
            pending <= 1'b0;
          end else if (consume) begin
            // A fresh tick arriving while an older one is queued is lost.
            if (sample_tick && pending) underrun <= 1'b1;
            pending      <= 1'b0;
            sample_valid <= 1'b1;
            if (state == S_FIRST) begin
              sample_out <= first_half;
              state      <= S_SECOND;
            end else begin
              sample_out <= second_half;
              read_addr  <= next_addr;
              state      <= S_FETCH;
              read_start <= 1'b1;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_sample_sequencer.sv
// tb/tb_audio_sample_sequencer.sv - self-checking bench for audio_sample_sequencer

module tb_audio_sample_sequencer;

  localparam int            AW = 24;
  localparam logic [AW-1:0] SA = 24'd0;
  localparam logic [AW-1:0] EA = 24'd3;

  logic          clk = 1'b0;
  logic          reset, sample_tick, play, reverse, restart, read_done;
  logic [31:0]   read_data;
  logic          read_start, sample_valid, underrun;
  logic [AW-1:0] read_addr;
  logic [15:0]   sample_out;

  always #5 clk = ~clk;

  audio_sample_sequencer #(.ADDR_W(AW), .START_ADDR(SA), .END_ADDR(EA)) dut (
    .clk(clk), .reset(reset), .sample_tick(sample_tick), .play(play),
    .reverse(reverse), .restart(restart), .read_start(read_start),
    .read_addr(read_addr), .read_data(read_data), .read_done(read_done),
    .sample_out(sample_out), .sample_valid(sample_valid), .underrun(underrun)
  );

  logic [31:0]   mem [0:3];
  int            n_checks = 0;
  int            n_fail = 0;

  // flash responder
  int            fl_lat, fl_cnt;
  bit            fl_busy;
  logic [AW-1:0] fl_addr;

  // scoreboard: expected request address and sample stream
  bit            sb_on, chk_ur, cur_dir, prev_rs;
  logic [AW-1:0] exp_addr, wa;
  logic [31:0]   cur_word;
  int            half, words_ready, n_valid, n_ur;

  function automatic logic [AW-1:0] adv(input logic [AW-1:0] a, input bit rev);
    if (rev) return (a == SA) ? EA : a - 24'd1;
    return (a == EA) ? SA : a + 24'd1;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    if (sample_valid) begin
      n_valid++;
      if (sb_on) begin
        check_eq("valid_play", 32'(play), 32'd1);
        if (half == 0) begin
          check_eq("sample_first", 32'(sample_out), 32'(cur_dir ? cur_word[31:16] : cur_word[15:0]));
          half = 1;
        end else begin
          check_eq("sample_second", 32'(sample_out), 32'(cur_dir ? cur_word[15:0] : cur_word[31:16]));
          half = 0;
          exp_addr = adv(wa, reverse);
        end
      end
    end
    if (underrun) n_ur++;
    if (chk_ur) check_eq("no_underrun", 32'(underrun), 32'd0);
    if (sb_on && read_start && !prev_rs) check_eq("req_addr", 32'(read_addr), 32'(exp_addr));
    prev_rs = read_start;
    if (read_done) begin
      read_done = 1'b0;
      words_ready++;
      if (sb_on) begin
        cur_word = mem[fl_addr[1:0]];
        cur_dir  = reverse;
        wa       = fl_addr;
      end
    end else if (!fl_busy && read_start) begin
      fl_busy = 1'b1;
      fl_cnt  = fl_lat;
      fl_addr = read_addr;
    end
    if (fl_busy) begin
      if (fl_cnt <= 1) begin
        read_done = 1'b1;
        read_data = mem[fl_addr[1:0]];
        fl_busy   = 1'b0;
      end else begin
        fl_cnt--;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b0; sample_tick = 1'b0; play = 1'b0; reverse = 1'b0; restart = 1'b0;
    read_done = 1'b0; fl_busy = 1'b0;
    cycle();
    read_done = 1'b0; fl_busy = 1'b0;
    check_eq("rst_read_start", 32'(read_start), 32'd0);
    check_eq("rst_read_addr", 32'(read_addr), 32'(SA));
    check_eq("rst_sample_out", 32'(sample_out), 32'd0);
    check_eq("rst_sample_valid", 32'(sample_valid), 32'd0);
    check_eq("rst_underrun", 32'(underrun), 32'd0);
    reset = 1'b1;
    exp_addr = SA; half = 0; prev_rs = 1'b0; words_ready = 0;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (words_ready == 0 && k < 60) begin
      cycle();
      k++;
    end
    check_eq({tag, "_done"}, 32'(words_ready != 0), 32'd1);
    if (words_ready > 0) words_ready--;
  endtask

  task automatic wait_rs(input string tag);
    int k = 0;
    while (!read_start && k < 20) begin
      cycle();
      k++;
    end
    check_eq({tag, "_rs"}, 32'(read_start), 32'd1);
  endtask

  task automatic tick_expect(input string tag, input logic [15:0] exp);
    sample_tick = 1'b1;
    cycle();
    sample_tick = 1'b0;
    check_eq({tag, "_v"}, 32'(sample_valid), 32'd1);
    check_eq({tag, "_s"}, 32'(sample_out), 32'(exp));
    cycle();
    check_eq({tag, "_p"}, 32'(sample_valid), 32'd0);
  endtask

  initial begin
    int ur0, nv0, n_tick_a, gap, k;
    bit held;

    mem[0] = 32'hBBBB_AAAA;
    mem[1] = $urandom;
    mem[2] = 32'h2222_1111;
    mem[3] = $urandom;
    read_data = '0;
    sb_on = 1'b1; chk_ur = 1'b0; n_valid = 0; n_ur = 0; fl_lat = 3;

    // basic forward playback, wrap at END_ADDR
    do_reset();
    play = 1'b1;
    wait_rs("t1");
    check_eq("t1_addr0", 32'(read_addr), 32'd0);
    wait_done("t1");
    tick_expect("t1_a", 16'hAAAA);
    tick_expect("t1_b", 16'hBBBB);
    check_eq("t1_addr1", 32'(read_addr), 32'd1);
    for (int w = 1; w < 4; w++) begin
      wait_done("t2");
      tick_expect("t2_lo", mem[w][15:0]);
      tick_expect("t2_hi", mem[w][31:16]);
    end
    check_eq("t2_wrap", 32'(read_addr), 32'(SA));
    wait_done("t2");
    tick_expect("t2_a", 16'hAAAA);
    tick_expect("t2_b", 16'hBBBB);
    wait_done("t2");
    tick_expect("t2_lo1", mem[1][15:0]);
    tick_expect("t2_hi1", mem[1][31:16]);

    // reverse from address 2 down through the START_ADDR wrap
    reverse = 1'b1;
    wait_done("t3");
    tick_expect("t3_hi2", 16'h2222);
    tick_expect("t3_lo2", 16'h1111);
    check_eq("t3_addr1", 32'(read_addr), 32'd1);
    wait_done("t3");
    tick_expect("t3_hi1", mem[1][31:16]);
    tick_expect("t3_lo1", mem[1][15:0]);
    wait_done("t3");
    tick_expect("t3_hi0", 16'hBBBB);
    tick_expect("t3_lo0", 16'hAAAA);
    check_eq("t3_wrap_end", 32'(read_addr), 32'(EA));

    // slow flash: one pending tick, then an underrun
    do_reset();
    fl_lat = 10; play = 1'b1;
    wait_rs("t4");
    ur0 = n_ur;
    cycle(); cycle();
    sample_tick = 1'b1; cycle(); sample_tick = 1'b0;
    wait_done("t4");
    cycle();
    check_eq("t4_pend_v", 32'(sample_valid), 32'd1);
    check_eq("t4_pend_s", 32'(sample_out), 32'hAAAA);
    check_eq("t4_no_ur", 32'(n_ur - ur0), 32'd0);
    tick_expect("t4_b", 16'hBBBB);
    ur0 = n_ur;
    cycle();
    sample_tick = 1'b1; cycle(); sample_tick = 1'b0;
    cycle();
    sample_tick = 1'b1; cycle(); sample_tick = 1'b0;
    wait_done("t4");
    check_eq("t4_one_ur", 32'(n_ur - ur0), 32'd1);
    cycle();
    check_eq("t4_pend2_v", 32'(sample_valid), 32'd1);
    check_eq("t4_pend2_s", 32'(sample_out), 32'(mem[1][15:0]));

    // restart during an in-flight fetch
    do_reset();
    sb_on = 1'b0; fl_lat = 3; play = 1'b1;
    wait_done("t5");
    tick_expect("t5_a", 16'hAAAA);
    tick_expect("t5_b", 16'hBBBB);
    wait_done("t5");
    tick_expect("t5_lo1", mem[1][15:0]);
    fl_lat = 8;
    tick_expect("t5_hi1", mem[1][31:16]);
    check_eq("t5_addr2", 32'(read_addr), 32'd2);
    restart = 1'b1; cycle(); restart = 1'b0;
    held = 1'b1; k = 0;
    while (words_ready == 0 && k < 30) begin
      if (!read_start) held = 1'b0;
      cycle();
      k++;
    end
    check_eq("t5_held", 32'(held), 32'd1);
    check_eq("t5_discard_done", 32'(words_ready), 32'd1);
    words_ready = 0;
    check_eq("t5_rs_drop", 32'(read_start), 32'd0);
    fl_lat = 3;
    wait_rs("t5_re");
    check_eq("t5_restart_addr", 32'(read_addr), 32'(SA));
    wait_done("t5");
    tick_expect("t5_ra", 16'hAAAA);
    tick_expect("t5_rb", 16'hBBBB);

    // pause, then reset in the middle of a fetch
    do_reset();
    sb_on = 1'b1; play = 1'b1;
    wait_done("t6");
    tick_expect("t6_a", 16'hAAAA);
    play = 1'b0;
    nv0 = n_valid; ur0 = n_ur;
    for (int i = 0; i < 20; i++) begin
      sample_tick = 1'b1; cycle(); sample_tick = 1'b0;
      cycle(); cycle();
    end
    check_eq("t6_no_valid", 32'(n_valid - nv0), 32'd0);
    check_eq("t6_hold", 32'(sample_out), 32'hAAAA);
    check_eq("t6_no_ur", 32'(n_ur - ur0), 32'd0);
    play = 1'b1;
    cycle();
    check_eq("t6_no_pend", 32'(sample_valid), 32'd0);
    tick_expect("t6_b", 16'hBBBB);
    cycle();
    check_eq("t6_mid_fetch", 32'(read_start), 32'd1);
    do_reset();

    // randomized playback against the scoreboard
    sb_on = 1'b1; chk_ur = 1'b1; play = 1'b1;
    nv0 = n_valid; n_tick_a = 0;
    gap = $urandom_range(12, 30);
    for (int c = 0; c < 1500; c++) begin
      fl_lat = $urandom_range(1, 6);
      if ($urandom_range(0, 39) == 0) reverse = ~reverse;
      sample_tick = 1'b0;
      if (gap == 0) begin
        sample_tick = 1'b1;
        n_tick_a++;
        gap = $urandom_range(12, 30);
      end else begin
        gap--;
      end
      cycle();
    end
    sample_tick = 1'b0;
    for (int c = 0; c < 40; c++) cycle();
    check_eq("rand_tick_count", 32'(n_valid - nv0), 32'(n_tick_a));
    for (int c = 0; c < 1500; c++) begin
      fl_lat = $urandom_range(1, 6);
      if ($urandom_range(0, 39) == 0) reverse = ~reverse;
      if ($urandom_range(0, 59) == 0) play = ~play;
      sample_tick = 1'b0;
      if (gap == 0) begin
        sample_tick = 1'b1;
        gap = $urandom_range(12, 30);
      end else begin
        gap--;
      end
      cycle();
    end
    sample_tick = 1'b0;
    chk_ur = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
